// File: rtl/seg7_pkg.sv
`default_nettype none
//============================================================================
// Module  : seg7_pkg
// Brief   : Shared types and constants for the 4-digit seven-segment
//           scan driver: FSM state encoding, hex glyph table and the
//           all-off patterns for anodes and segments.
// Rev     : 1.0  initial release
//============================================================================
package seg7_pkg;

    // Scan FSM: a digit is either being shown or all anodes are dark
    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_e;

    // Active-low off patterns
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low glyphs {g,f,e,d,c,b,a}; element n is the glyph for hex n
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
//============================================================================
// Module  : hex_to_seg7
// Brief   : Combinational hex nibble to active-low seven-segment glyph.
// Rev     : 1.0  initial release
//============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_hex];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
//============================================================================
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed driver for a 4-digit common-anode display.
//           Each scan tick advances SHOW -> BLANK(xBLANK_TICKS) -> next
//           digit. value/dp_mask are captured once per frame so a
//           mid-frame update never mixes two values on screen.
//           Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
// Rev     : 1.0  initial release
//============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int BLANK_TICKS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    // Counter preload on SHOW -> BLANK; unused when there is no blank phase
    localparam logic [3:0] c_BLANK_LOAD = (BLANK_TICKS > 0) ? 4'(BLANK_TICKS - 1) : 4'd0;

    state_e      r_state;
    state_e      w_next_state;
    logic [1:0]  r_digit;
    logic [1:0]  w_next_digit;
    logic [3:0]  r_blank_cnt;
    logic [3:0]  w_next_cnt;
    logic [15:0] r_shadow_val;
    logic [15:0] w_next_shadow_val;
    logic [3:0]  r_shadow_dp;
    logic [3:0]  w_next_shadow_dp;
    logic        w_load;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;
    logic [3:0]  w_lz_off;
    logic [3:0]  w_an_next;
    logic [6:0]  w_seg_next;
    logic        w_dp_next;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_frame_done;

    // Next scan position assuming this cycle is a tick
    always_comb begin
        w_next_state = r_state;
        w_next_digit = r_digit;
        w_next_cnt   = r_blank_cnt;
        case (r_state)
            SHOW: begin
                if (BLANK_TICKS == 0) begin
                    w_next_digit = r_digit + 2'd1;
                end else begin
                    w_next_state = BLANK;
                    w_next_cnt   = c_BLANK_LOAD;
                end
            end
            BLANK: begin
                if (r_blank_cnt != 4'd0) begin
                    w_next_cnt = r_blank_cnt - 4'd1;
                end else begin
                    w_next_state = SHOW;
                    w_next_digit = r_digit + 2'd1;
                end
            end
            default: begin
                w_next_state = BLANK;
            end
        endcase
    end

    // Any transition landing on SHOW of digit 0 starts a new frame
    assign w_load            = (w_next_state == SHOW) && (w_next_digit == 2'd0);
    assign w_next_shadow_val = w_load ? value   : r_shadow_val;
    assign w_next_shadow_dp  = w_load ? dp_mask : r_shadow_dp;

    // Select the nibble of the digit about to be displayed
    always_comb begin
        w_nibble = w_next_shadow_val[3:0];
        case (w_next_digit)
            2'd0: w_nibble = w_next_shadow_val[3:0];
            2'd1: w_nibble = w_next_shadow_val[7:4];
            2'd2: w_nibble = w_next_shadow_val[11:8];
            2'd3: w_nibble = w_next_shadow_val[15:12];
            default: w_nibble = w_next_shadow_val[3:0];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_nibble),
        .o_seg (w_glyph)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Digit k stays dark while it and every higher nibble are zero
    assign w_lz_off[3] = (w_next_shadow_val[15:12] == 4'd0);
    assign w_lz_off[2] = (w_next_shadow_val[15:8]  == 8'd0);
    assign w_lz_off[1] = (w_next_shadow_val[15:4]  == 12'd0);
    assign w_lz_off[0] = 1'b0;
`else
    assign w_lz_off = 4'b0000;
`endif

    // Output patterns for the upcoming state
    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        w_dp_next  = 1'b1;
        if (w_next_state == SHOW) begin
            w_an_next  = w_lz_off[w_next_digit] ? AN_OFF : ~(4'b0001 << w_next_digit);
            w_seg_next = w_glyph;
            w_dp_next  = ~w_next_shadow_dp[w_next_digit];
        end
    end

    // Scan state and frame shadows advance only on tick
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= BLANK;
            r_digit      <= 2'd3;
            r_blank_cnt  <= 4'd0;
            r_shadow_val <= 16'd0;
            r_shadow_dp  <= 4'd0;
        end else if (tick) begin
            r_state      <= w_next_state;
            r_digit      <= w_next_digit;
            r_blank_cnt  <= w_next_cnt;
            r_shadow_val <= w_next_shadow_val;
            r_shadow_dp  <= w_next_shadow_dp;
        end
    end

    // Registered display outputs; frame_done is a single-cycle strobe
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else if (tick) begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_frame_done <= w_load;
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
//============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Self-checking bench for seg7_scan_driver with BLANK_TICKS=1
//           and BLANK_TICKS=0 instances sharing the same stimulus.
// Rev     : 1.0  initial release
//============================================================================
module tb_seg7_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] value;
    logic [3:0]  dp_mask;

    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0, fd1, fd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seg7_scan_driver #(.BLANK_TICKS(1)) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .value      (value),
        .dp_mask    (dp_mask),
        .an         (an1),
        .seg        (seg1),
        .dp         (dp1),
        .frame_done (fd1)
    );

    seg7_scan_driver #(.BLANK_TICKS(0)) u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .value      (value),
        .dp_mask    (dp_mask),
        .an         (an0),
        .seg        (seg0),
        .dp         (dp0),
        .frame_done (fd0)
    );

    typedef struct {
        logic [15:0] v;
        logic [3:0]  m;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One tick cycle with the given inputs; returns #1 after the edge
    task automatic tick_with(input logic [15:0] v, input logic [3:0] m);
        @(negedge clock);
        value   = v;
        dp_mask = m;
        tick    = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    // Hold reset low n edges with tick high, checking both instances each edge
    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b0;
        tick  = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("rst%0d_an1", k),  32'(an1),  32'hF);
            chk($sformatf("rst%0d_seg1", k), 32'(seg1), 32'h7F);
            chk($sformatf("rst%0d_dp1", k),  32'(dp1),  32'h1);
            chk($sformatf("rst%0d_fd1", k),  32'(fd1),  32'h0);
            chk($sformatf("rst%0d_an0", k),  32'(an0),  32'hF);
            chk($sformatf("rst%0d_fd0", k),  32'(fd0),  32'h0);
        end
        @(negedge clock);
        reset = 1'b1;
        tick  = 1'b0;
    endtask

    logic [3:0] exp_an0 [5];
    logic [6:0] exp_seg0 [5];
    logic [3:0] exp_anl [8];
    logic [6:0] exp_segl [8];
    logic       exp_dpl [8];

    initial begin
        reset   = 1'b1;
        tick    = 1'b0;
        value   = 16'h1234;
        dp_mask = 4'h0;

        // Three frames on the BLANK_TICKS=1 instance; value switches
        // mid-frame 2, dp_mask switches mid-frame 2 and again for frame 3
        tbl[0]  = '{16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b1};
        tbl[1]  = '{16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[2]  = '{16'h1234, 4'h0, 4'hD, 7'h30, 1'b1, 1'b0};
        tbl[3]  = '{16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[4]  = '{16'h1234, 4'h0, 4'hB, 7'h24, 1'b1, 1'b0};
        tbl[5]  = '{16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[6]  = '{16'h1234, 4'h0, 4'h7, 7'h79, 1'b1, 1'b0};
        tbl[7]  = '{16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[8]  = '{16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b1};
        tbl[9]  = '{16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[10] = '{16'h1234, 4'h0, 4'hD, 7'h30, 1'b1, 1'b0};
        tbl[11] = '{16'hABCD, 4'hF, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[12] = '{16'hABCD, 4'hF, 4'hB, 7'h24, 1'b1, 1'b0};
        tbl[13] = '{16'hABCD, 4'hF, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[14] = '{16'hABCD, 4'hF, 4'h7, 7'h79, 1'b1, 1'b0};
        tbl[15] = '{16'hABCD, 4'hF, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[16] = '{16'hABCD, 4'h5, 4'hE, 7'h21, 1'b0, 1'b1};
        tbl[17] = '{16'hABCD, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[18] = '{16'hABCD, 4'h5, 4'hD, 7'h46, 1'b1, 1'b0};
        tbl[19] = '{16'hABCD, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[20] = '{16'hABCD, 4'h5, 4'hB, 7'h03, 1'b0, 1'b0};
        tbl[21] = '{16'hABCD, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b0};
        tbl[22] = '{16'hABCD, 4'h5, 4'h7, 7'h08, 1'b1, 1'b0};
        tbl[23] = '{16'hABCD, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b0};

        exp_seg0 = '{7'h40, 7'h0E, 7'h40, 7'h40, 7'h40};
        exp_segl = '{7'h12, 7'h7F, 7'h40, 7'h7F, 7'h40, 7'h7F, 7'h40, 7'h7F};
        exp_dpl  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef SEG7_LZ_BLANK_EN
        exp_an0  = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hE};
        exp_anl  = '{4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`else
        exp_an0  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        exp_anl  = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
`endif

        // Reset with tick held high
        do_reset(3);

        // Table-driven scan with shadowing
        for (int i = 0; i < 24; i++) begin
            tick_with(tbl[i].v, tbl[i].m);
            chk($sformatf("tbl%0d_an", i),  32'(an1),  32'(tbl[i].an));
            chk($sformatf("tbl%0d_seg", i), 32'(seg1), 32'(tbl[i].seg));
            chk($sformatf("tbl%0d_dp", i),  32'(dp1),  32'(tbl[i].dp));
            chk($sformatf("tbl%0d_fd", i),  32'(fd1),  32'(tbl[i].fd));
        end

        // Outputs hold between ticks; frame_done drops after one cycle
        tick_with(16'hABCD, 4'h5);
        chk("hold_fd_pulse", 32'(fd1), 32'h1);
        repeat (3) @(posedge clock);
        #1;
        chk("hold_an",  32'(an1),  32'hE);
        chk("hold_seg", 32'(seg1), 32'h21);
        chk("hold_dp",  32'(dp1),  32'h0);
        chk("hold_fd",  32'(fd1),  32'h0);

        // No blank phase: digits advance on every tick
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            tick_with(16'h00F0, 4'h0);
            chk($sformatf("nb%0d_an", i), 32'(an0), 32'(exp_an0[i]));
            if (exp_an0[i] != 4'hF)
                chk($sformatf("nb%0d_seg", i), 32'(seg0), 32'(exp_seg0[i]));
            chk($sformatf("nb%0d_fd", i), 32'(fd0), (i == 0 || i == 4) ? 32'h1 : 32'h0);
        end

        // Leading zeros
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            tick_with(16'h0005, 4'h1);
            chk($sformatf("lz%0d_an", i), 32'(an1), 32'(exp_anl[i]));
            if (exp_anl[i] != 4'hF || (i % 2) == 1) begin
                chk($sformatf("lz%0d_seg", i), 32'(seg1), 32'(exp_segl[i]));
                chk($sformatf("lz%0d_dp", i),  32'(dp1),  32'(exp_dpl[i]));
            end
        end

        // Reset while digit 2 is lit
        do_reset(1);
        for (int i = 0; i < 5; i++)
            tick_with(16'h1234, 4'h0);
        chk("mid_pre_an", 32'(an1), 32'hB);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_an",  32'(an1),  32'hF);
        chk("mid_rst_seg", 32'(seg1), 32'h7F);
        @(negedge clock);
        reset = 1'b1;
        tick_with(16'h1234, 4'h0);
        chk("mid_post_an",  32'(an1),  32'hE);
        chk("mid_post_fd",  32'(fd1),  32'h1);
        chk("mid_post_seg", 32'(seg1), 32'h19);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
